// File: rtl/ahb_apb_xfer_fsm.sv
// Hclk-domain AHB-slave / APB-master transfer controller feeding the Hclk->Pclk synchronizers.
// Optional feature: define BRDG_XFER_CNT_EN to add the Xfer_cnt completed-transfer counter.
module ahb_apb_xfer_fsm #(
  parameter int SETUP_CYC  = 4,
  parameter int ENABLE_CYC = 4,
  parameter int RD_CYC     = 3
) (
  input  logic        Hclk,
  input  logic        Hresetn,
  input  logic        Hwrite,
  input  logic        Hreadyin,
  input  logic [1:0]  Htrans,
  input  logic [31:0] Haddr,
  input  logic [31:0] Hwdata,
  input  logic [31:0] Prdata_hclk,
  output logic        Hreadyout,
  output logic        Hresp,
  output logic [31:0] Hrdata,
  output logic        Penable_hclk,
  output logic        Pwrite_hclk,
  output logic [2:0]  Pselx_hclk,
  output logic [31:0] Paddr_hclk,
`ifdef BRDG_XFER_CNT_EN
  output logic [31:0] Pwdata_hclk,
  output logic [15:0] Xfer_cnt
`else
  output logic [31:0] Pwdata_hclk
`endif
);

  localparam int MAX_SE  = (SETUP_CYC > ENABLE_CYC) ? SETUP_CYC : ENABLE_CYC;
  localparam int MAX_CYC = (MAX_SE > RD_CYC) ? MAX_SE : RD_CYC;
  localparam int CW      = $clog2(MAX_CYC) + 1;

  localparam logic [CW-1:0] SETUP_LAST  = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] ENABLE_LAST = CW'(ENABLE_CYC - 1);
  localparam logic [CW-1:0] RD_LAST     = CW'(RD_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, WDATA, SETUP, ENABLE, RDWAIT, DONE, ERR1, ERR2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [31:0]   addr_lat, addr_lat_nxt;
  logic          write_lat, write_lat_nxt;
  logic [2:0]    sel_lat, sel_lat_nxt;

  logic          hreadyout_nxt, hresp_nxt, penable_nxt, pwrite_nxt;
  logic [2:0]    pselx_nxt;
  logic [31:0]   hrdata_nxt, paddr_nxt, pwdata_nxt;

  logic          valid;
  logic [2:0]    haddr_sel;

  // Each slave owns a 64 MB window starting at 0x8000_0000; 000 marks unmapped.
  function automatic logic [2:0] decode(input logic [31:0] a);
    case (a[31:26])
      6'b100000: decode = 3'b001;
      6'b100001: decode = 3'b010;
      6'b100010: decode = 3'b100;
      default:   decode = 3'b000;
    endcase
  endfunction

  assign valid     = Hreadyin && (Htrans inside {2'b10, 2'b11});
  assign haddr_sel = decode(Haddr);

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    addr_lat_nxt  = addr_lat;
    write_lat_nxt = write_lat;
    sel_lat_nxt   = sel_lat;
    penable_nxt   = Penable_hclk;
    pwrite_nxt    = Pwrite_hclk;
    pselx_nxt     = Pselx_hclk;
    paddr_nxt     = Paddr_hclk;
    pwdata_nxt    = Pwdata_hclk;
    hrdata_nxt    = Hrdata;

    case (state)
      // DONE behaves like IDLE for acceptance so back-to-back transfers see no gap.
      IDLE, DONE: begin
        if (state == DONE) state_nxt = IDLE;
        if (valid) begin
          addr_lat_nxt  = Haddr;
          write_lat_nxt = Hwrite;
          sel_lat_nxt   = haddr_sel;
          cnt_nxt       = '0;
          if (haddr_sel == 3'b000) begin
            state_nxt = ERR1;
          end else if (Hwrite) begin
            state_nxt = WDATA;
          end else begin
            state_nxt  = SETUP;
            pselx_nxt  = haddr_sel;
            paddr_nxt  = Haddr;
            pwrite_nxt = 1'b0;
          end
        end
      end
      WDATA: begin
        pwdata_nxt = Hwdata;
        pselx_nxt  = sel_lat;
        paddr_nxt  = addr_lat;
        pwrite_nxt = write_lat;
        cnt_nxt    = '0;
        state_nxt  = SETUP;
      end
      SETUP: begin
        if (cnt == SETUP_LAST) begin
          cnt_nxt     = '0;
          penable_nxt = 1'b1;
          state_nxt   = ENABLE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ENABLE: begin
        if (cnt == ENABLE_LAST) begin
          cnt_nxt     = '0;
          penable_nxt = 1'b0;
          pselx_nxt   = 3'b000;
          state_nxt   = write_lat ? DONE : RDWAIT;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      RDWAIT: begin
        if (cnt == RD_LAST) begin
          cnt_nxt    = '0;
          hrdata_nxt = Prdata_hclk;
          state_nxt  = DONE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ERR1:    state_nxt = ERR2;
      ERR2:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    hreadyout_nxt = (state_nxt == IDLE) || (state_nxt == DONE) || (state_nxt == ERR2);
    hresp_nxt     = (state_nxt == ERR1) || (state_nxt == ERR2);
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state        <= IDLE;
      cnt          <= '0;
      addr_lat     <= '0;
      write_lat    <= 1'b0;
      sel_lat      <= 3'b000;
      Hreadyout    <= 1'b1;
      Hresp        <= 1'b0;
      Hrdata       <= '0;
      Penable_hclk <= 1'b0;
      Pwrite_hclk  <= 1'b0;
      Pselx_hclk   <= 3'b000;
      Paddr_hclk   <= '0;
      Pwdata_hclk  <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      addr_lat     <= addr_lat_nxt;
      write_lat    <= write_lat_nxt;
      sel_lat      <= sel_lat_nxt;
      Hreadyout    <= hreadyout_nxt;
      Hresp        <= hresp_nxt;
      Hrdata       <= hrdata_nxt;
      Penable_hclk <= penable_nxt;
      Pwrite_hclk  <= pwrite_nxt;
      Pselx_hclk   <= pselx_nxt;
      Paddr_hclk   <= paddr_nxt;
      Pwdata_hclk  <= pwdata_nxt;
    end
  end

`ifdef BRDG_XFER_CNT_EN
  // DONE is only reachable from a successful APB phase, so errors never count.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      Xfer_cnt <= '0;
    end else if (state_nxt == DONE && state != DONE) begin
      Xfer_cnt <= Xfer_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ahb_apb_xfer_fsm.sv
// Randomized self-checking bench for ahb_apb_xfer_fsm against a cycle-index reference model.
module tb_ahb_apb_xfer_fsm;

  localparam int S = 4;
  localparam int E = 4;
  localparam int R = 3;

  logic        Hclk = 1'b0;
  logic        Hresetn, Hwrite, Hreadyin;
  logic [1:0]  Htrans;
  logic [31:0] Haddr, Hwdata, Prdata_hclk;
  logic        Hreadyout, Hresp, Penable_hclk, Pwrite_hclk;
  logic [2:0]  Pselx_hclk;
  logic [31:0] Hrdata, Paddr_hclk, Pwdata_hclk;
`ifdef BRDG_XFER_CNT_EN
  logic [15:0] Xfer_cnt;
  logic [15:0] model_cnt = '0;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] model_paddr = '0, model_pwdata = '0, model_hrdata = '0;
  logic        model_pwrite = 1'b0;

  typedef struct packed {
    logic       hready;
    logic       hresp;
    logic       penable;
    logic [2:0] psel;
  } ctl_t;

  ahb_apb_xfer_fsm #(.SETUP_CYC(S), .ENABLE_CYC(E), .RD_CYC(R)) dut (
    .Hclk(Hclk), .Hresetn(Hresetn), .Hwrite(Hwrite), .Hreadyin(Hreadyin),
    .Htrans(Htrans), .Haddr(Haddr), .Hwdata(Hwdata), .Prdata_hclk(Prdata_hclk),
    .Hreadyout(Hreadyout), .Hresp(Hresp), .Hrdata(Hrdata),
    .Penable_hclk(Penable_hclk), .Pwrite_hclk(Pwrite_hclk), .Pselx_hclk(Pselx_hclk),
    .Paddr_hclk(Paddr_hclk),
`ifdef BRDG_XFER_CNT_EN
    .Pwdata_hclk(Pwdata_hclk), .Xfer_cnt(Xfer_cnt)
`else
    .Pwdata_hclk(Pwdata_hclk)
`endif
  );

  always #5 Hclk = ~Hclk;

  function automatic logic [2:0] region_sel(input logic [31:0] a);
    if (a >= 32'h8000_0000 && a <= 32'h83FF_FFFF) return 3'b001;
    if (a >= 32'h8400_0000 && a <= 32'h87FF_FFFF) return 3'b010;
    if (a >= 32'h8800_0000 && a <= 32'h8BFF_FFFF) return 3'b100;
    return 3'b000;
  endfunction

  // Expected control outputs k cycles after the accepting edge.
  function automatic ctl_t model_ctl(input logic wr, input logic [2:0] sel, input int k);
    int off, last;
    if (sel == 3'b000) begin
      if (k == 1) return '{1'b0, 1'b1, 1'b0, 3'b000};
      if (k == 2) return '{1'b1, 1'b1, 1'b0, 3'b000};
      return '{1'b1, 1'b0, 1'b0, 3'b000};
    end
    off  = wr ? 1 : 0;
    last = wr ? (1 + S + E + 1) : (S + E + R + 1);
    if (k <= off)          return '{1'b0, 1'b0, 1'b0, 3'b000};
    if (k <= off + S)      return '{1'b0, 1'b0, 1'b0, sel};
    if (k <= off + S + E)  return '{1'b0, 1'b0, 1'b1, sel};
    if (k < last)          return '{1'b0, 1'b0, 1'b0, 3'b000};
    return '{1'b1, 1'b0, 1'b0, 3'b000};
  endfunction

  // One transfer; entered and left at a negedge, so consecutive calls are back-to-back.
  task automatic test_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input string name, output int low_cnt);
    logic [2:0] sel;
    int         last_k;
    ctl_t       exp_c, act_c;
    sel     = region_sel(addr);
    last_k  = (sel == 3'b000) ? 3 : (wr ? (2 + S + E) : (S + E + R + 1));
    low_cnt = 0;
    Hreadyin = 1'b1; Htrans = 2'b10; Hwrite = wr; Haddr = addr;
    Prdata_hclk = rdata; Hwdata = $urandom;
    @(posedge Hclk);
    for (int k = 1; k <= last_k; k++) begin
      @(negedge Hclk);
      if (k == 1) begin
        Htrans = 2'($urandom_range(0, 1));
        Hwdata = wr ? wdata : $urandom;
      end else begin
        Hwdata = $urandom;
      end
      Haddr  = $urandom;
      Hwrite = 1'($urandom_range(0, 1));
      if (k == last_k && sel != 3'b000) begin
        model_paddr  = addr;
        model_pwrite = wr;
        if (wr) model_pwdata = wdata;
        else    model_hrdata = rdata;
`ifdef BRDG_XFER_CNT_EN
        model_cnt = model_cnt + 16'd1;
`endif
      end
      exp_c = model_ctl(wr, sel, k);
      act_c = {Hreadyout, Hresp, Penable_hclk, Pselx_hclk};
      vectors++;
      if (act_c !== exp_c) begin
        miscompares++;
        $display("[TB] FAIL %s ctl k=%0d: got %b required %b", name, k, act_c, exp_c);
      end
      if (!Hreadyout) low_cnt++;
      if (exp_c.psel != 3'b000) begin
        vectors++;
        if ({Paddr_hclk, Pwrite_hclk} !== {addr, wr}) begin
          miscompares++;
          $display("[TB] FAIL %s apb_addr k=%0d: got %h/%b required %h/%b",
                   name, k, Paddr_hclk, Pwrite_hclk, addr, wr);
        end
        if (wr) begin
          vectors++;
          if (Pwdata_hclk !== wdata) begin
            miscompares++;
            $display("[TB] FAIL %s pwdata k=%0d: got %h required %h", name, k, Pwdata_hclk, wdata);
          end
        end
      end
      if (k == last_k) begin
        vectors++;
        if ({Paddr_hclk, Pwrite_hclk, Pwdata_hclk, Hrdata} !==
            {model_paddr, model_pwrite, model_pwdata, model_hrdata}) begin
          miscompares++;
          $display("[TB] FAIL %s retained: got %h %b %h %h required %h %b %h %h", name,
                   Paddr_hclk, Pwrite_hclk, Pwdata_hclk, Hrdata,
                   model_paddr, model_pwrite, model_pwdata, model_hrdata);
        end
`ifdef BRDG_XFER_CNT_EN
        vectors++;
        if (Xfer_cnt !== model_cnt) begin
          miscompares++;
          $display("[TB] FAIL %s xfer_cnt: got %h required %h", name, Xfer_cnt, model_cnt);
        end
`endif
      end
    end
    Htrans = 2'b00;
  endtask

  task automatic test_reset();
    Hresetn = 1'b1; Hreadyin = 1'b1; Htrans = 2'b00; Hwrite = 1'b0;
    Haddr = '0; Hwdata = '0; Prdata_hclk = '0;
    #2 Hresetn = 1'b0;
    repeat (2) @(negedge Hclk);
    vectors++;
    if ({Hreadyout, Hresp, Hrdata, Penable_hclk, Pwrite_hclk, Pselx_hclk, Paddr_hclk, Pwdata_hclk}
        !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0}) begin
      miscompares++;
      $display("[TB] FAIL reset_values: got ready=%b resp=%b psel=%b paddr=%h",
               Hreadyout, Hresp, Pselx_hclk, Paddr_hclk);
    end
    Hresetn = 1'b1;
    repeat (2) @(negedge Hclk);
    vectors++;
    if ({Hreadyout, Hresp, Pselx_hclk} !== {1'b1, 1'b0, 3'b000}) begin
      miscompares++;
      $display("[TB] FAIL reset_release: got ready=%b resp=%b psel=%b required 1 0 000",
               Hreadyout, Hresp, Pselx_hclk);
    end
  endtask

  task automatic test_reset_mid();
    Hreadyin = 1'b1; Htrans = 2'b10; Hwrite = 1'b1; Haddr = 32'h8800_0000;
    @(posedge Hclk);
    @(negedge Hclk);
    Htrans = 2'b00; Hwdata = 32'hA5A5_0001;
    repeat (S + 1) @(negedge Hclk);
    vectors++;
    if ({Penable_hclk, Pselx_hclk} !== {1'b1, 3'b100}) begin
      miscompares++;
      $display("[TB] FAIL mid_enable: got en=%b psel=%b required 1 100", Penable_hclk, Pselx_hclk);
    end
    Hresetn = 1'b0;
    #1;
    vectors++;
    if ({Hreadyout, Hresp, Hrdata, Penable_hclk, Pwrite_hclk, Pselx_hclk, Paddr_hclk, Pwdata_hclk}
        !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0}) begin
      miscompares++;
      $display("[TB] FAIL async_reset: got ready=%b en=%b psel=%b paddr=%h pwdata=%h",
               Hreadyout, Penable_hclk, Pselx_hclk, Paddr_hclk, Pwdata_hclk);
    end
    model_paddr = '0; model_pwdata = '0; model_hrdata = '0; model_pwrite = 1'b0;
`ifdef BRDG_XFER_CNT_EN
    model_cnt = '0;
`endif
    @(negedge Hclk);
    Hresetn = 1'b1;
    repeat (2) @(negedge Hclk);
    vectors++;
    if ({Hreadyout, Hresp, Penable_hclk, Pselx_hclk} !== {1'b1, 1'b0, 1'b0, 3'b000}) begin
      miscompares++;
      $display("[TB] FAIL after_reset_idle: got ready=%b resp=%b en=%b psel=%b",
               Hreadyout, Hresp, Penable_hclk, Pselx_hclk);
    end
  endtask

  task automatic test_write();
    int lo;
    test_xfer(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, $urandom, "write", lo);
    vectors++;
    if (lo !== 1 + S + E) begin
      miscompares++;
      $display("[TB] FAIL write_latency: got %0d required 9", lo);
    end
    @(negedge Hclk);
  endtask

  task automatic test_read();
    int lo;
    test_xfer(1'b0, 32'h8800_0004, $urandom, 32'h1234_5678, "read", lo);
    vectors++;
    if (lo !== S + E + R || Hrdata !== 32'h1234_5678) begin
      miscompares++;
      $display("[TB] FAIL read_latency: got %0d/%h required 11/12345678", lo, Hrdata);
    end
    @(negedge Hclk);
  endtask

  task automatic test_error();
    int lo;
    test_xfer(1'b0, 32'h9000_0000, $urandom, $urandom, "error", lo);
    vectors++;
    if (lo !== 1) begin
      miscompares++;
      $display("[TB] FAIL error_low_cycles: got %0d required 1", lo);
    end
  endtask

  task automatic test_back_to_back();
    int lo;
    test_xfer(1'b1, 32'h8000_0100, 32'h0BAD_F00D, $urandom, "b2b_first", lo);
    test_xfer(1'b0, 32'h8400_0000, $urandom, 32'hCAFE_0042, "b2b_second", lo);
    test_xfer(1'b1, 32'h8400_0020, 32'h7777_1234, $urandom, "b2b_third", lo);
    vectors++;
    if (Hrdata !== 32'hCAFE_0042) begin
      miscompares++;
      $display("[TB] FAIL b2b_hrdata_hold: got %h required cafe0042", Hrdata);
    end
    @(negedge Hclk);
  endtask

  task automatic test_ignore();
    for (int i = 0; i < 8; i++) begin
      Haddr = 32'h8000_0000 + ($urandom & 32'h0BFF_FFFF);
      Hwrite = 1'($urandom_range(0, 1));
      if (i % 2 == 0) begin
        Htrans = 2'($urandom_range(0, 1)); Hreadyin = 1'($urandom_range(0, 1));
      end else begin
        Htrans = 2'($urandom_range(2, 3)); Hreadyin = 1'b0;
      end
      @(negedge Hclk);
      vectors++;
      if ({Hreadyout, Hresp, Penable_hclk, Pselx_hclk} !== {1'b1, 1'b0, 1'b0, 3'b000}) begin
        miscompares++;
        $display("[TB] FAIL ignore_%0d: got ready=%b resp=%b psel=%b", i, Hreadyout, Hresp, Pselx_hclk);
      end
    end
    Hreadyin = 1'b1; Htrans = 2'b10; Hwrite = 1'b0; Haddr = 32'hC000_0000;
    @(posedge Hclk);
    @(negedge Hclk);
    Htrans = 2'b00;
    @(negedge Hclk);
    Htrans = 2'b10; Haddr = 32'h8000_0000;
    @(negedge Hclk);
    Htrans = 2'b00;
    vectors++;
    if ({Hreadyout, Hresp, Pselx_hclk} !== {1'b1, 1'b0, 3'b000}) begin
      miscompares++;
      $display("[TB] FAIL ignore_in_err2: got ready=%b resp=%b psel=%b required 1 0 000",
               Hreadyout, Hresp, Pselx_hclk);
    end
    @(negedge Hclk);
  endtask

  task automatic test_random();
    int          lo, r;
    logic [31:0] addr;
    logic [31:0] bases [3] = '{32'h8000_0000, 32'h8400_0000, 32'h8800_0000};
    for (int n = 0; n < 24; n++) begin
      r = $urandom_range(0, 3);
      if (r < 3) begin
        addr = bases[r] + ($urandom & 32'h03FF_FFFF);
      end else begin
        addr = 32'h9000_0000;
        for (int t = 0; t < 16; t++) begin
          addr = $urandom;
          if (region_sel(addr) == 3'b000) break;
        end
        if (region_sel(addr) != 3'b000) addr = 32'h0000_1000;
      end
      test_xfer(1'($urandom_range(0, 1)), addr, $urandom, $urandom, "random", lo);
      if ($urandom_range(0, 1) == 1) @(negedge Hclk);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_error();
    test_back_to_back();
    test_ignore();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ahb_apb_xfer_fsm.md
Name: ahb_apb_xfer_fsm

Overview:
- Hclk-domain AHB-slave and APB-master controller. It sits directly upstream of the Hclk→Pclk CDC synchronizer stage.
- Accepts single AHB transfers, decodes the address to one of 3 APB slaves, and drives the APB control/data signals in the Hclk domain.
- Holds each APB phase for a parameterised number of Hclk cycles so the downstream multi-flop synchronizers capture it.
- Samples the synchronized read data after a programmable wait.

Parameters:
- SETUP_CYC, 4, Hclk cycles the SETUP phase is held (Pselx valid, Penable=0); legal range ≥1.
- ENABLE_CYC, 4, Hclk cycles the ENABLE phase is held (Penable=1); legal range ≥1.
- RD_CYC, 3, extra Hclk cycles after ENABLE before Prdata_hclk is sampled; legal range ≥1.

Ports:
- Hclk  in  1  clock.
- Hresetn  in  1  asynchronous active-low reset.
- Hwrite  in  1  AHB direction (1=write), address phase.
- Hreadyin  in  1  AHB bus ready.
- Htrans  in  2  AHB transfer type (10 NONSEQ, 11 SEQ valid; 00/01 ignored).
- Haddr  in  32  AHB address.
- Hwdata  in  32  AHB write data, data phase.
- Prdata_hclk  in  32  read data already synchronized into Hclk.
- Hreadyout  out  1  AHB ready to master.
- Hresp  out  1  AHB response (0 OKAY, 1 ERROR).
- Hrdata  out  32  AHB read data.
- Penable_hclk  out  1  APB enable.
- Pwrite_hclk  out  1  APB direction.
- Pselx_hclk  out  3  one-hot APB slave select.
- Paddr_hclk  out  32  APB address.
- Pwdata_hclk  out  32  APB write data.

Behaviour:
- Clocking and reset: one clock, Hclk. Hresetn is asynchronous and active-low. All outputs are registered.
- Reset values: state IDLE, Hreadyout=1, Hresp=0, Hrdata=0, Penable=0, Pwrite=0, Pselx=000, Paddr=0, Pwdata=0, counter=0.
- Reset mid-transfer aborts immediately to the reset values. No completion is signalled.
- Valid transfer: Hreadyin=1 & Htrans[1]=1 while in IDLE.
- Address decode:
  - 0x8000_0000–0x83FF_FFFF → 001
  - 0x8400_0000–0x87FF_FFFF → 010
  - 0x8800_0000–0x8BFF_FFFF → 100
  - anything else → unmapped.
- IDLE:
  - Hreadyout=1, Pselx=000, Penable=0.
  - On a valid transfer, latch Haddr, Hwrite and the decode result; Hreadyout→0 on the next edge.
  - Next state: unmapped→ERR1; write→WDATA; read→SETUP. Invalid/IDLE/BUSY Htrans: stay in IDLE.
- WDATA (1 cycle): latch Hwdata into Pwdata → SETUP.
- SETUP:
  - Pselx, Paddr, Pwrite driven from the latched values; Penable=0.
  - Counter counts SETUP_CYC cycles, then → ENABLE.
- ENABLE:
  - Penable=1; other APB outputs held.
  - After ENABLE_CYC cycles → Pselx=000, Penable=0.
  - Next state: write→DONE; read→RDWAIT.
- RDWAIT:
  - APB outputs idle. After RD_CYC cycles, Hrdata←Prdata_hclk → DONE.
- DONE:
  - Hreadyout=1, Hresp=0 for exactly one cycle; the state is treated as IDLE for acceptance.
  - A valid transfer presented in this cycle is accepted (back-to-back).
- ERR1: Hresp=1, Hreadyout=0 (1 cycle) → ERR2.
- ERR2: Hresp=1, Hreadyout=1 (1 cycle) → IDLE. A transfer presented here is ignored.
- No APB activity on error. Paddr/Pwrite/Pwdata retain their last values while idle; only Pselx and Penable return to 0.
- Phase counter: width $clog2(max param)+1, reset at each phase entry, never wraps.
- Latency (Hreadyout low → high):
  - write = 1 + SETUP_CYC + ENABLE_CYC cycles
  - read = SETUP_CYC + ENABLE_CYC + RD_CYC cycles
- Hwdata/Haddr changes during a transfer have no effect.
- Hrdata holds its value until the next read completes.

Optional Feature:
- Macro: BRDG_XFER_CNT_EN.
- When defined:
  - Extra output Xfer_cnt [15:0], reset 0.
  - Increments by 1 on entry to DONE, wrapping 0xFFFF→0x0000.
  - Errors are not counted.
- When undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset: Hresetn=0 asserted mid-ENABLE → all outputs at reset values in the same cycle; after release, IDLE with Hreadyout=1.
- Write:
  - Stimulus: Haddr=0x8000_0010, Hwrite=1, Htrans=10, Hwdata=0xDEAD_BEEF, defaults.
  - Required: Pselx=001 and Paddr=0x8000_0010 for 4 cycles with Penable=0, then 4 cycles with Penable=1; Pwdata=0xDEAD_BEEF; Hreadyout low for 9 cycles.
- Read:
  - Stimulus: Haddr=0x8800_0004, Hwrite=0, Prdata_hclk=0x1234_5678.
  - Required: Pselx=100; Hrdata=0x1234_5678 at DONE; Hreadyout low for 11 cycles.
- Error: Haddr=0x9000_0000 → Pselx stays 000; Hresp=1 for 2 cycles with Hreadyout 0 then 1.
- Back-to-back: second valid transfer (Haddr=0x8400_0000) presented in the DONE cycle → accepted; Pselx=010 SETUP follows without an IDLE gap.
- Ignore: Htrans=00 or Hreadyin=0 with a valid address → no state change. With BRDG_XFER_CNT_EN, 0xFFFF completions followed by 1 more → Xfer_cnt=0x0000.
